// File: rtl/store_buffer_pkg.sv
// Shared memory-stage definitions: store-buffer entry layout, default depth and
// access-size helpers. Nothing core-specific belongs here.
package store_buffer_pkg;

  localparam int unsigned SB_DEPTH_DEFAULT = 4;
  // Loads and stores are matched on the word address; bits below this are the byte offset.
  localparam int unsigned WORD_LSB = 2;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        is_half;
    logic        is_byte;
  } sb_entry_t;

  function automatic logic is_subword(input logic half, input logic bsel);
    return half | bsel;
  endfunction

endpackage

// File: rtl/store_buffer_match.sv
// Word-address compare across all valid store-buffer entries, reporting the
// youngest match and whether any matching entry is a sub-word store.
module sb_match
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH_DEFAULT,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  sb_entry_t        entries_i [DEPTH],
  input  logic [PTR_W-1:0] head_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic [31:0]      addr_i,
  output logic             hit_o,
  output logic             sub_hit_o,
  output logic [PTR_W-1:0] hit_idx_o
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest from the head so the last match seen is the youngest.
  always_comb begin
    hit_o     = 1'b0;
    sub_hit_o = 1'b0;
    hit_idx_o = '0;
    idx       = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = head_i + PTR_W'(k);
      if ((CNT_W'(k) < count_i) &&
          (entries_i[idx].addr[31:WORD_LSB] == addr_i[31:WORD_LSB])) begin
        hit_o     = 1'b1;
        hit_idx_o = idx;
        if (is_subword(entries_i[idx].is_half, entries_i[idx].is_byte)) begin
          sub_hit_o = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between EX/MEM and data memory: drains the head entry
// when the write port is free and forwards word stores to matching word loads.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = SB_DEPTH_DEFAULT,
  parameter int unsigned p_num = 0
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 EX_MEM_MemWrite,
  input  logic                 EX_MEM_MemRead,
  input  logic                 EX_MEM_HalfControl,
  input  logic                 EX_MEM_ByteControl,
  input  logic [31:0]          EX_MEM_ALUResult,
  input  logic [31:0]          EX_MEM_rt_val,
  input  logic                 Mem_Grant,
  output logic                 Mem_WrEn,
  output logic [31:0]          Mem_Addr,
  output logic [31:0]          Mem_WrData,
  output logic                 Mem_Half,
  output logic                 Mem_Byte,
  output logic                 SB_Fwd_Valid,
  output logic [31:0]          SB_Fwd_Data,
  output logic                 SB_Stall,
  output logic                 SB_Empty,
  output logic [$clog2(DEPTH):0] SB_Count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  sb_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             hit, sub_hit, full, load_hazard, drain, push;
  logic [PTR_W-1:0] hit_idx;

  sb_match #(.DEPTH(DEPTH)) u_match (
    .entries_i (mem_q),
    .head_i    (head_q),
    .count_i   (count_q),
    .addr_i    (EX_MEM_ALUResult),
    .hit_o     (hit),
    .sub_hit_o (sub_hit),
    .hit_idx_o (hit_idx)
  );

  always_comb begin
    SB_Empty    = (count_q == '0);
    full        = (count_q == CNT_W'(DEPTH));
    load_hazard = EX_MEM_MemRead & hit &
                  (sub_hit | EX_MEM_HalfControl | EX_MEM_ByteControl);
    // A pending load only yields the write port when it is waiting on the buffer itself.
    drain       = !SB_Empty & Mem_Grant & (!EX_MEM_MemRead | load_hazard);
    push        = EX_MEM_MemWrite & !(full & !drain);

    SB_Stall     = (EX_MEM_MemWrite & full & !drain) | load_hazard;
    SB_Fwd_Valid = EX_MEM_MemRead & hit & !load_hazard;
    SB_Fwd_Data  = SB_Fwd_Valid ? mem_q[hit_idx].data : '0;
    SB_Count     = count_q;

    Mem_WrEn   = drain;
    Mem_Addr   = mem_q[head_q].addr;
    Mem_WrData = mem_q[head_q].data;
    Mem_Half   = mem_q[head_q].is_half;
    Mem_Byte   = mem_q[head_q].is_byte;

    head_d  = head_q + PTR_W'(drain);
    tail_d  = tail_q + PTR_W'(push);
    count_d = count_q + CNT_W'(push) - CNT_W'(drain);
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (push) begin
        mem_q[tail_q] <= '{addr:    EX_MEM_ALUResult,
                           data:    EX_MEM_rt_val,
                           is_half: EX_MEM_HalfControl,
                           is_byte: EX_MEM_ByteControl};
      end
    end
  end

endmodule
